// File: rtl/pipeline_credit_receiver_pkg.sv
// Shared defaults and helpers for the credit-based receiver at the end of a
// valid-only, fixed-latency pipeline.
package pipeline_credit_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_WIDTH = 32;

    // Width needed to hold the values 0..n inclusive.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

    typedef logic [clog2p1(DEF_DEPTH)-1:0] credit_cnt_t;

endpackage

// File: rtl/credit_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are never reset; validity is tracked by the owner.
module credit_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipeline_credit_receiver.sv
// Credit issuer and output FIFO for a stall-free fixed-latency pipeline:
// admits launches only while buffer space is guaranteed for every beat in flight.
module pipeline_credit_receiver
    import pipeline_credit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CNT_W = clog2p1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             pipe_valid,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_S = (CNT_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_inflight;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_issue_fire;
    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;
    logic             w_drop;
    logic             w_no_credit_owed;
    logic [CNT_W:0]   w_committed;

    // Credits depend only on registered state, so issue_ready has no input path.
    assign w_committed      = {1'b0, r_occ} + {1'b0, r_inflight};
    assign issue_ready      = (w_committed < DEPTH_S);
    assign out_valid        = (r_occ != '0);

    assign w_issue_fire     = issue_valid & issue_ready;
    assign w_pop            = out_valid & out_ready;
    assign w_full           = (r_occ == DEPTH_C);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
    assign w_push_ok        = pipe_valid & (~w_full | w_pop);
    assign w_drop           = pipe_valid & w_full & ~w_pop;
    assign w_no_credit_owed = (r_inflight == '0);

    credit_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push_ok),
        .waddr (r_wr_ptr),
        .wdata (pipe_data),
        .raddr (r_rd_ptr),
        .rdata (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + CNT_W'(1);
                2'b01:   r_occ <= r_occ - CNT_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // An unexpected beat (nothing in flight) must not drive the count negative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue_fire, pipe_valid & ~w_no_credit_owed})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (pipe_valid && w_no_credit_owed) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_pipeline_credit_receiver.sv
// Bench for pipeline_credit_receiver: models a 2-stage producer pipeline and
// keeps a queue scoreboard of beats that should be buffered by the receiver.
module tb_pipeline_credit_receiver;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             overflow_err;
    logic             underflow_err;

    pipeline_credit_receiver #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .pipe_valid    (pipe_valid),
        .pipe_data     (pipe_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard and reference state.
    logic [WIDTH-1:0] q[$];
    int               m_inf = 0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    int               n_pop = 0;

    // Bench-side pipeline, latency 2.
    logic             pl_v [2];
    logic [WIDTH-1:0] pl_d [2];

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] idat;
        logic             ordy;
        logic             exp_ir;
        logic             exp_ov;
        logic [WIDTH-1:0] exp_head;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check outputs, update the model,
    // then advance the pipeline model across the rising edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] idat, input logic ordy,
                         input logic fpv, input logic [WIDTH-1:0] fdat,
                         input logic have_exp, input logic exp_ir, input logic exp_ov,
                         input logic [WIDTH-1:0] exp_head);
        logic fire;
        logic pop;
        logic pv;
        logic [WIDTH-1:0] pd;
        @(negedge clk);
        issue_valid = iv;
        out_ready   = ordy;
        pv          = pl_v[1] | fpv;
        pd          = fpv ? fdat : pl_d[1];
        pipe_valid  = pv;
        pipe_data   = pd;
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, (q.size() + m_inf) < DEPTH});
        chk("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
        chk("underflow_err", {31'd0, underflow_err}, {31'd0, m_unf});
        if (have_exp) begin
            chk("tbl_issue_ready", {31'd0, issue_ready}, {31'd0, exp_ir});
            chk("tbl_out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov) chk("tbl_head", out_data, exp_head);
        end
        fire = iv & issue_ready;
        pop  = (q.size() != 0) & ordy;
        if (pop) begin
            void'(q.pop_front());
            n_pop++;
        end
        if (pv) begin
            if (q.size() < DEPTH) q.push_back(pd);
            else m_ovf = 1'b1;
            if (m_inf == 0) m_unf = 1'b1;
            else m_inf--;
        end
        if (fire) m_inf++;
        @(posedge clk);
        pl_v[1] = pl_v[0];
        pl_d[1] = pl_d[0];
        pl_v[0] = fire;
        pl_d[0] = idat;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, ordy, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic force_push(input logic [WIDTH-1:0] d);
        cycle(1'b0, '0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int pops_before;
        tbl[0]  = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 32'h3, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 32'h1};
        tbl[4]  = '{1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 32'h1};
        tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1};
        tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1};
        tbl[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1};
        tbl[8]  = '{1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h2};
        tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2};
        tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2};

        pl_v[0] = 1'b0; pl_v[1] = 1'b0;
        pl_d[0] = '0;   pl_d[1] = '0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        pipe_valid  = 1'b0;
        pipe_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
        chk("rst_unf", {31'd0, underflow_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);

        // Fill to full with stalled output, pop once, refill through the freed credit.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].iv, tbl[i].idat, tbl[i].ordy, 1'b0, '0,
                  1'b1, tbl[i].exp_ir, tbl[i].exp_ov, tbl[i].exp_head);
        end

        // Streaming with out_ready high: one pop per cycle across pointer wrap.
        pops_before = n_pop;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'h100 + i, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        end
        chk("throughput_pops", n_pop - pops_before, 32'd20);
        repeat (6) idle(1'b1);
        chk("drained", q.size(), 32'd0);

        // Unsolicited beat: underflow flag, data still buffered, flag sticky.
        force_push(32'hAA);
        idle(1'b0);
        chk("unf_set", {31'd0, underflow_err}, 32'd1);
        idle(1'b0);
        chk("unf_sticky", {31'd0, underflow_err}, 32'd1);

        // Push into a full FIFO without a pop: dropped, head unchanged.
        force_push(32'hB1);
        force_push(32'hB2);
        force_push(32'hB3);
        force_push(32'hCC);
        idle(1'b0);
        chk("ovf_set", {31'd0, overflow_err}, 32'd1);
        chk("ovf_head", out_data, 32'hAA);
        idle(1'b1);
        idle(1'b0);
        chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);

        // Asynchronous reset with three beats buffered.
        chk("pre_rst_count", q.size(), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("async_rst_ovf", {31'd0, overflow_err}, 32'd0);
        chk("async_rst_unf", {31'd0, underflow_err}, 32'd0);
        q.delete();
        m_inf = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        pl_v[0] = 1'b0; pl_v[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_credit_receiver.md
Name: pipeline_credit_receiver

Overview:
- Receiving end of a valid-only, fixed-latency generated pipeline, which has no stall input.
- Issues admission credits to the pipeline's upstream producer and tracks the transactions in flight.
- Captures every pipe_valid beat into an internal FIFO and presents it downstream on a ready/valid interface with backpressure.
- Guarantees no beat is dropped when the producer honours issue_ready; flags sticky errors when it does not.

Parameters:
- WIDTH, 32, payload width of pipe_data/out_data.
- DEPTH, 4, FIFO entries and total credits; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and in-flight counters; derived, not overridden.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert supplied externally.
- issue_valid  input  1  producer wants to launch a beat into the pipeline this cycle.
- issue_ready  output  1  credit available; a launch fires when issue_valid & issue_ready.
- pipe_valid  input  1  pipeline output valid (pipeline's out_valid).
- pipe_data  input  WIDTH  pipeline output payload.
- out_valid  output  1  FIFO head valid.
- out_data  output  WIDTH  FIFO head payload.
- out_ready  input  1  downstream accepts the head when out_valid & out_ready.
- overflow_err  output  1  sticky: pipe_valid arrived with the FIFO full and no same-cycle pop.
- underflow_err  output  1  sticky: pipe_valid arrived with inflight == 0.

Behaviour:
- Reset (rst_n low, asynchronous) clears wr_ptr, rd_ptr, occ, inflight, and both error flags.
  - Output values in reset: out_valid = 0, issue_ready = 1, both error flags 0.
  - out_data is don't-care while out_valid = 0.
  - Storage array is not reset.
- Credit rule: issue_ready = (occ + inflight) < DEPTH.
  - Computed from registered state only; no combinational path from any input.
- Fire events:
  - issue_fire = issue_valid & issue_ready.
  - push = pipe_valid.
  - pop = out_valid & out_ready.
- inflight update:
  - +1 on issue_fire, -1 on push; both in the same cycle leaves it unchanged.
  - Never decremented below 0: push with inflight == 0 sets underflow_err, and the data is still pushed if space exists.
- occ update:
  - +1 on push, -1 on pop; both in the same cycle leaves it unchanged.
- Push handling:
  - Writes pipe_data to mem[wr_ptr] and advances wr_ptr modulo DEPTH (natural wrap).
  - Push while occ == DEPTH and no pop: beat dropped, overflow_err set, pointers and occ unchanged.
  - Push while full with a simultaneous pop is legal: the freed slot is reused.
- Output presentation:
  - out_valid = (occ != 0); out_data = mem[rd_ptr].
  - A pop advances rd_ptr modulo DEPTH.
- Latency: a beat pushed in cycle N is visible on out_valid/out_data in cycle N+1; there is no empty-FIFO bypass.
- Downstream stall: out_valid/out_data are held stable while out_ready = 0.
- Credit sufficiency: with in-order issue, the credit rule bounds occ + inflight <= DEPTH, so a compliant producer can never overflow regardless of pipeline latency.
- Error flags are sticky; they clear only on reset.
- Reset asserted mid-operation discards all in-flight accounting and buffered beats.
  - Beats still in the pipeline that arrive after reset release raise underflow_err; this is the correct, intended report.

Decomposition:
- Shared package pipeline_credit_pkg:
  - localparam default DEPTH/WIDTH.
  - Counter-width function clog2p1.
  - Typedef credit_cnt_t.
- One sub-module, credit_fifo_mem: a DEPTH x WIDTH register array with write port (we, waddr, wdata) and async read port (raddr, rdata), no reset.
- Pointer, counter and credit logic live in the top.

Test Plan (DEPTH=4, WIDTH=32, bench pipeline latency 2):
- Reset, then idle -> issue_ready=1, out_valid=0, overflow_err=0, underflow_err=0.
- Issue 4 beats back-to-back, out_ready=0 -> issue_ready drops to 0 after the 4th fire, out_valid rises in the cycle after the first push, and 0x1,0x2,0x3,0x4 are held in order.
- From full, pulse out_ready for 1 cycle -> 0x1 popped, issue_ready=1 next cycle, a new issue lands 2 cycles later with no overflow_err.
- Continuous issue with out_ready=1 -> throughput 1 beat/cycle, data in order across pointer wrap for 16 beats, occ never exceeds 4.
- Force pipe_valid with no prior issue -> underflow_err=1 and stays 1.
- Force a push while full with out_ready=0 -> overflow_err=1, stored head unchanged.
- Assert rst_n low with 3 beats buffered -> out_valid=0 immediately (asynchronous), issue_ready=1.
